// File: rtl/regfile_param.sv
// regfile_param -- parametrised 3-port register file (2 comb read, 1 sync write)
//
// Purpose:
//   Generic DATA_W x 2**ADDR_W register file with an optional hardwired zero
//   entry and a hardware clear sequencer. After reset the sequencer walks every
//   entry and writes zero. The file reports busy until that walk completes.
//
// Parameters:
//   DATA_W   bits per register
//   ADDR_W   address width, NUM_REGS = 2**ADDR_W
//   ZERO_REG 1: entry 0 reads as 0 and ignores writes; 0: ordinary storage
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   : same-cycle write-to-read forwarding (write-first) when READY.
//   Undefined : no forwarding; a same-cycle read returns the pre-write value.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset, starts the clear walk
//   rfw_enable    in   write enable, port 3
//   rfr_address1  in   read address, port 1
//   rfr_address2  in   read address, port 2
//   rfw_address3  in   write address, port 3
//   rfw_data3     in   write data, port 3
//   rfr_data1     out  read data, port 1 (combinational)
//   rfr_data2     out  read data, port 2 (combinational)
//   rf_busy       out  high while the clear walk runs

module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rfw_enable,
    input  logic [ADDR_W-1:0] rfr_address1,
    input  logic [ADDR_W-1:0] rfr_address2,
    input  logic [ADDR_W-1:0] rfw_address3,
    input  logic [DATA_W-1:0] rfw_data3,
    output logic [DATA_W-1:0] rfr_data1,
    output logic [DATA_W-1:0] rfr_data2,
    output logic              rf_busy
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam int                NUM_RD   = 2;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              host_wr;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                // The last entry is zeroed on this edge, so READY follows it.
                if (clr_idx_q == LAST_IDX) state_d = ST_READY;
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs -- busy flag and the single storage write port, shared
    // between the clear walk and the host. Host writes in CLEAR are
    // dropped, not queued.
    // ------------------------------------------------------------------
    always_comb begin
        rf_busy   = (state_q == ST_CLEAR);
        host_wr   = (state_q == ST_READY) && rfw_enable &&
                    !((ZERO_REG != 0) && (rfw_address3 == '0));
        mem_we    = 1'b0;
        mem_waddr = rfw_address3;
        mem_wdata = rfw_data3;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_idx_q;
            mem_wdata = '0;
        end else if (host_wr) begin
            mem_we    = 1'b1;
        end
    end

    // Storage carries no reset; the clear walk provides the known state.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;

    assign rd_addr[0] = rfr_address1;
    assign rd_addr[1] = rfr_address2;
    assign rfr_data1  = rd_data[0];
    assign rfr_data2  = rd_data[1];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        always_comb begin
            rd_data[p] = mem_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
            // host_wr already excludes busy and the hardwired zero entry.
            if (host_wr && (rd_addr[p] == rfw_address3)) rd_data[p] = rfw_data3;
`endif
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) rd_data[p] = '0;
            if (rf_busy) rd_data[p] = '0;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        rfw_enable;
    logic [4:0]  ra1, ra2, wa;
    logic [31:0] wd;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    // dut_a: hardwired zero entry, dut_b: entry 0 is ordinary storage
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .rfw_enable(rfw_enable),
        .rfr_address1(ra1), .rfr_address2(ra2), .rfw_address3(wa),
        .rfw_data3(wd), .rfr_data1(rd1_a), .rfr_data2(rd2_a), .rf_busy(busy_a)
    );

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .rfw_enable(rfw_enable),
        .rfr_address1(ra1), .rfr_address2(ra2), .rfw_address3(wa),
        .rfw_data3(wd), .rfr_data1(rd1_b), .rfr_data2(rd2_b), .rf_busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rfw_enable = 1'b1;
        wa         = a;
        wd         = d;
        tick();
        rfw_enable = 1'b0;
    endtask

    // Counts cycles until busy drops; reads must be 0 throughout busy.
    // With inj set, host writes to entry 9 are attempted mid-clear.
    task automatic wait_ready(input bit inj, output int cnt);
        cnt = 0;
        ra1 = 5'd9;
        wa  = 5'd9;
        wd  = 32'hAAAA5555;
        while (busy_a && cnt < 100) begin
            rfw_enable = inj && (cnt == 3 || cnt == 20);
            tick();
            cnt++;
            if (busy_a) begin
                chk("busy_rd1_a", rd1_a, 32'h0);
                chk("busy_rd1_b", rd1_b, 32'h0);
                chk("busy_match", 32'(busy_b), 32'd1);
            end
        end
        rfw_enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rfw_enable = 1'b0;
        ra1 = '0; ra2 = '0; wa = '0; wd = '0;

        // reset, clear with writes attempted during it
        tick();
        chk("rst_busy_a", 32'(busy_a), 32'd1);
        chk("rst_busy_b", 32'(busy_b), 32'd1);
        reset = 1'b0;
        wait_ready(1'b1, n);
        chk("clr_len", 32'(n), 32'd32);
        chk("ready_b", 32'(busy_b), 32'd0);
        ra1 = 5'd9; #1;
        chk("wr_in_clear", rd1_a, 32'h0);

        // preload, then reset clears
        wr(5'd5, 32'hDEADBEEF);
        wr(5'd31, 32'hDEADBEEF);
        ra1 = 5'd5; ra2 = 5'd31; #1;
        chk("pre5", rd1_a, 32'hDEADBEEF);
        chk("pre31", rd2_a, 32'hDEADBEEF);
        reset = 1'b1; tick(); reset = 1'b0;
        wait_ready(1'b0, n);
        chk("clr_len2", 32'(n), 32'd32);
        ra1 = 5'd5; ra2 = 5'd31; #1;
        chk("clr5", rd1_a, 32'h0);
        chk("clr31", rd2_a, 32'h0);

        // basic write/read, both ports same entry
        wr(5'd7, 32'h12345678);
        ra1 = 5'd7; ra2 = 5'd7; #1;
        chk("rd7_p1", rd1_a, 32'h12345678);
        chk("rd7_p2", rd2_a, 32'h12345678);

        // zero register
        wr(5'd0, 32'hFFFFFFFF);
        ra1 = 5'd0; ra2 = 5'd0; #1;
        chk("zr_on", rd1_a, 32'h0);
        chk("zr_on_p2", rd2_a, 32'h0);
        chk("zr_off", rd1_b, 32'hFFFFFFFF);

        // reset mid-clear restarts the walk
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (10) tick();
        chk("mid_busy", 32'(busy_a), 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_busy2", 32'(busy_a), 32'd1);
        wait_ready(1'b0, n);
        chk("clr_len3", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(i); #1;
            chk("all0_a1", rd1_a, 32'h0);
            chk("all0_a2", rd2_a, 32'h0);
            chk("all0_b1", rd1_b, 32'h0);
        end

        // same-cycle read/write
        wr(5'd3, 32'h11111111);
        rfw_enable = 1'b1; wa = 5'd3; wd = 32'h0BADF00D; ra1 = 5'd3; #1;
        chk("same_cyc", rd1_a, BYP ? 32'h0BADF00D : 32'h11111111);
        tick();
        rfw_enable = 1'b0; #1;
        chk("after_edge", rd1_a, 32'h0BADF00D);

        // same-cycle write to entry 0: never forwarded when hardwired
        wr(5'd0, 32'hFFFFFFFF);
        rfw_enable = 1'b1; wa = 5'd0; wd = 32'hCAFEBABE; ra1 = 5'd0; #1;
        chk("zr_byp_a", rd1_a, 32'h0);
        chk("zr_byp_b", rd1_b, BYP ? 32'hCAFEBABE : 32'hFFFFFFFF);
        tick();
        rfw_enable = 1'b0; #1;
        chk("zr_after_a", rd1_a, 32'h0);
        chk("zr_after_b", rd1_b, 32'hCAFEBABE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised three-port register file for the datapath: two combinational read ports and one synchronous write port.
- Successor to the fixed 32x32 file. Adds generic width/depth, an optional hardwired zero register, and a hardware clear sequencer that zeroes every entry after reset.
- Exposes a busy flag so the control unit can stall issue until the file is clean.
- Optional write-to-read bypass supports pipelined datapaths.

Parameters:
- DATA_W, 32, bits per register.
- ADDR_W, 5, address width; depth NUM_REGS = 2**ADDR_W.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes; when 0 entry 0 is ordinary storage.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset; starts the clear sequence.
- rfw_enable  input  1  write enable for port 3.
- rfr_address1  input  ADDR_W  read port 1 address.
- rfr_address2  input  ADDR_W  read port 2 address.
- rfw_address3  input  ADDR_W  write port 3 address.
- rfw_data3  input  DATA_W  write port 3 data.
- rfr_data1  output  DATA_W  read port 1 data (combinational).
- rfr_data2  output  DATA_W  read port 2 data (combinational).
- rf_busy  output  1  high while the clear sequence runs; file unusable.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- FSM states are CLEAR and READY.
  - reset=1 at a rising edge: state=CLEAR, clear counter clr_idx=0. This applies from any state, including mid-clear, where the counter restarts at 0.
  - In CLEAR, each cycle writes 0 to entry clr_idx, then clr_idx++.
  - When clr_idx == NUM_REGS-1 is written, the next state is READY.
  - The clear takes exactly NUM_REGS cycles after reset deasserts (32 by default).
  - READY holds until the next reset.
- rf_busy = 1 in CLEAR and 0 in READY. It is registered, so it is 1 in the cycle after reset is sampled.
- While rf_busy=1:
  - rfw_enable is ignored; host writes are dropped, not queued.
  - rfr_data1 and rfr_data2 are forced to 0.
- In READY, a write with rfw_enable=1 at a rising edge stores rfw_data3 at rfw_address3.
- If ZERO_REG=1 and rfw_address3==0, the write is discarded.
- Reads are combinational: rfr_dataN = entry[rfr_addressN]. If ZERO_REG=1 and the address is 0, the output is 0.
- Both read ports may address the same entry simultaneously; each returns the same value.
- Read and write to the same address in the same cycle (no bypass): the read returns the old value until the edge and the new value after it.
- No arithmetic; widths pass through unchanged. Out-of-range addresses cannot occur because depth is exactly 2**ADDR_W.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When READY, rfw_enable=1, and rfr_addressN == rfw_address3 (and not the zeroed entry 0), rfr_dataN = rfw_data3 combinationally in the same cycle. This is write-first behaviour for pipelines that write and read in one cycle.
  - Bypass is disabled while rf_busy=1.
  - Bypass is disabled for address 0 when ZERO_REG=1.
- Undefined: no forwarding; same-cycle read returns the pre-write contents.

Test Plan:
- Reset clear:
  - Preload entries 5 and 31 with 0xDEADBEEF.
  - Assert reset 1 cycle.
  - Required: rf_busy=1 for exactly 32 cycles, then 0; entries 5 and 31 read 0x00000000.
- Basic write/read:
  - After READY, write 0x12345678 to entry 7.
  - Next cycle set rfr_address1=7 and rfr_address2=7.
  - Required: both outputs 0x12345678.
- Zero register:
  - With ZERO_REG=1, write 0xFFFFFFFF to entry 0.
  - Required: reads of entry 0 return 0x00000000.
  - Repeat with ZERO_REG=0. Required: read returns 0xFFFFFFFF.
- Writes during clear:
  - Assert rfw_enable with address 9, data 0xAAAA5555 at cycle 3 of the clear.
  - Required: after READY, entry 9 reads 0; rfr_data1 is 0 throughout busy.
- Reset mid-clear:
  - Reassert reset at clear cycle 10.
  - Required: rf_busy stays high and deasserts 32 cycles after the second reset; all entries read 0.
- Same-cycle read/write:
  - Write 0x0BADF00D to entry 3 while rfr_address1=3 (old value 0x11111111).
  - Required with REGFILE_BYPASS_EN: rfr_data1=0x0BADF00D in that cycle.
  - Required without it: 0x11111111 in that cycle, 0x0BADF00D after the edge.
